// File: rtl/reg_load_seq_pkg.sv
// Shared definitions for the register load sequencer.
//   ld_state_e : 2-bit sequencer state encoding
//   DEST_A/B   : destination register select values
//   ext_hi     : high byte for a byte load (zero or sign fill)
package reg_load_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    WRITE = 2'd3
  } ld_state_e;

  localparam logic DEST_A = 1'b0;
  localparam logic DEST_B = 1'b1;

  // High byte of a byte load: replicated bit 7 when sign-extending, else zero.
  function automatic logic [7:0] ext_hi(input logic [7:0] lo, input logic sext);
    return (sext && lo[7]) ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/reg_load_seq_if.sv
// Bus bundle for the register load sequencer.
//   ld_*      : load request from the control side (ld_start sampled in IDLE)
//   busy      : sequencer occupied
//   mem_*     : byte-wide memory read handshake (req held until ack)
//   sec_*     : assembled value and per-register write strobes
// slave  : the sequencer's view; master : the requester/memory side.
interface reg_load_seq_if;
  logic        ld_start;
  logic [15:0] ld_addr;
  logic        ld_dest;
  logic        ld_byte;
  logic        ld_sext;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] sec_out;
  logic        sec_we_a;
  logic        sec_we_b;

  modport slave (
    input  ld_start, ld_addr, ld_dest, ld_byte, ld_sext, mem_ack, mem_rdata,
    output busy, mem_addr, mem_req, sec_out, sec_we_a, sec_we_b
  );

  modport master (
    output ld_start, ld_addr, ld_dest, ld_byte, ld_sext, mem_ack, mem_rdata,
    input  busy, mem_addr, mem_req, sec_out, sec_we_a, sec_we_b
  );
endinterface

// File: rtl/reg_load_seq.sv
// Register load sequencer: fetches a byte or little-endian 16-bit word from
// byte-wide memory and strobes it into general register A or B.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : reg_load_seq_if.slave (load request, memory handshake, write port)
// Outputs are decoded from state and holding registers, so every output is
// at its reset value as soon as rst rises.
module reg_load_seq
  import reg_load_seq_pkg::*;
(
  input logic          clk,
  input logic          rst,
  reg_load_seq_if.slave bus
);

  ld_state_e   state_q, state_d;
  logic [15:0] addr_q;
  logic        dest_q;
  logic        byte_q;
  logic        sext_q;
  logic [7:0]  lo_q;
  logic [7:0]  hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.ld_start) state_d = RD_LO;
      RD_LO:   if (bus.mem_ack)  state_d = byte_q ? WRITE : RD_HI;
      RD_HI:   if (bus.mem_ack)  state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= 16'h0000;
      dest_q <= DEST_A;
      byte_q <= 1'b0;
      sext_q <= 1'b0;
      lo_q   <= 8'h00;
      hi_q   <= 8'h00;
    end else begin
      case (state_q)
        IDLE: if (bus.ld_start) begin
          addr_q <= bus.ld_addr;
          dest_q <= bus.ld_dest;
          byte_q <= bus.ld_byte;
          sext_q <= bus.ld_sext;
        end
        RD_LO: if (bus.mem_ack) begin
          lo_q <= bus.mem_rdata;
          // Byte loads never visit RD_HI, so the fill byte is settled here.
          if (byte_q) hi_q <= ext_hi(bus.mem_rdata, sext_q);
        end
        RD_HI: if (bus.mem_ack) hi_q <= bus.mem_rdata;
        default: ;
      endcase
    end
  end

  // 16-bit add wraps 0xFFFF to 0x0000 for the high-byte fetch.
  assign bus.mem_addr = (state_q == RD_HI) ? addr_q + 16'd1 : addr_q;
  assign bus.mem_req  = (state_q == RD_LO) || (state_q == RD_HI);
  assign bus.busy     = (state_q != IDLE);
  assign bus.sec_out  = {hi_q, lo_q};
  assign bus.sec_we_a = (state_q == WRITE) && (dest_q == DEST_A);
  assign bus.sec_we_b = (state_q == WRITE) && (dest_q == DEST_B);

endmodule

// File: tb/tb_reg_load_seq.sv
// Bench for reg_load_seq: a memory responder with programmable wait states,
// a load driver that pushes expected writes into a queue, and a monitor that
// pops and compares on each write strobe.
module tb_reg_load_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_load_seq_if bus();
  reg_load_seq dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        dest;
    logic [15:0] val;
    int          t0;
    int          lat;   // -1: latency not checked
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem [0:65535];
  int          chk_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  int          wait_n = 0;
  int          wcnt = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [15:0] prev_addr = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s act=%h exp=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory: ack after wait_n request cycles; random ack noise when idle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      wcnt          = 0;
    end else begin
      #1;
      if (bus.mem_req) begin
        if (wcnt >= wait_n) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr];
          wcnt          = 0;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = 8'($urandom);
          wcnt++;
        end
      end else begin
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = 8'($urandom);
        wcnt          = 0;
      end
    end
  end

  // Monitor: request stability, and scoreboard on write strobes.
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (prev_req && !prev_ack) begin
        chk("req_held", 32'(bus.mem_req), 32'd1);
        chk("addr_held", 32'(bus.mem_addr), 32'(prev_addr));
      end
      if (bus.mem_req) chk("req_while_busy", 32'(bus.busy), 32'd1);
      if (bus.sec_we_a || bus.sec_we_b) begin
        chk("we_onehot", 32'(bus.sec_we_a & bus.sec_we_b), 32'd0);
        chk("busy_in_write", 32'(bus.busy), 32'd1);
        if (exp_q.size() == 0) begin
          chk("spurious_we", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("we_dest", 32'(bus.sec_we_b), 32'(e.dest));
          chk("sec_out", 32'(bus.sec_out), 32'(e.val));
          if (e.lat >= 0) chk("latency", 32'(cyc - e.t0), 32'(e.lat));
        end
      end
      prev_req  = bus.mem_req;
      prev_ack  = bus.mem_ack;
      prev_addr = bus.mem_addr;
    end
  end

  // Issue one load in the first IDLE cycle, then optionally pulse ld_start
  // at random while busy (those pulses must be ignored).
  task automatic do_load(input logic [15:0] a, input logic d, input logic b,
                         input logic s, input int wn, input int noise);
    int n = 0;
    logic [15:0] a1;
    logic [15:0] v;
    exp_t e;
    @(negedge clk);
    bus.ld_start = 1'b0;
    while (bus.busy && n < 100) begin @(negedge clk); n++; end
    if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
    wait_n = wn;
    a1 = a + 16'd1;
    if (!b)                    v = {mem[a1], mem[a]};
    else if (s && mem[a][7])   v = 16'hFF00 | 16'(mem[a]);
    else                       v = 16'(mem[a]);
    bus.ld_start = 1'b1;
    bus.ld_addr  = a;
    bus.ld_dest  = d;
    bus.ld_byte  = b;
    bus.ld_sext  = s;
    e.dest = d; e.val = v; e.t0 = cyc; e.lat = (wn == 0) ? (b ? 2 : 3) : -1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.ld_start = 1'b0;
    bus.ld_addr  = 16'($urandom);
    bus.ld_dest  = 1'($urandom);
    bus.ld_byte  = 1'($urandom);
    bus.ld_sext  = 1'($urandom);
    for (int k = 0; k < noise; k++) begin
      @(negedge clk);
      bus.ld_start = bus.busy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.ld_addr  = 16'($urandom);
      bus.ld_dest  = 1'($urandom);
      bus.ld_byte  = 1'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h1000] = 8'h34; mem[16'h1001] = 8'h12;
    mem[16'h2000] = 8'h80;
    mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
    mem[16'h3000] = 8'h5A; mem[16'h3001] = 8'hC3;
    bus.ld_start = 1'b0; bus.ld_addr = 16'h0; bus.ld_dest = 1'b0;
    bus.ld_byte  = 1'b0; bus.ld_sext = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_we", 32'({bus.sec_we_a, bus.sec_we_b}), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_sec_out", 32'(bus.sec_out), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    do_load(16'h1000, 1'b0, 1'b0, 1'b0, 0, 0);  // 0x1234 to A, 3 cycles
    do_load(16'h2000, 1'b1, 1'b1, 1'b1, 0, 0);  // 0xFF80 to B, 2 cycles
    do_load(16'h2000, 1'b1, 1'b1, 1'b0, 0, 0);  // 0x0080 to B
    do_load(16'hFFFF, 1'b0, 1'b0, 1'b0, 0, 0);  // wrap: 0xABCD
    do_load(16'h3000, 1'b1, 1'b0, 1'b0, 4, 12); // wait states + busy noise
    do_load(16'h3000, 1'b0, 1'b1, 1'b1, 4, 8);

    for (int i = 0; i < 40; i++)
      do_load(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));

    // Reset while waiting in the high-byte fetch abandons the load.
    do_load(16'h4000, 1'b0, 1'b0, 1'b0, 4, 0);
    begin
      int n = 0;
      while (!(bus.mem_req && bus.mem_addr == 16'h4001) && n < 50) begin
        @(negedge clk); n++;
      end
      chk("reached_rd_hi", 32'(bus.mem_addr), 32'h4001);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
    chk("mid_rst_we", 32'({bus.sec_we_a, bus.sec_we_b}), 32'd0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_rst_sec_out", 32'(bus.sec_out), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);  // monitor flags any strobe as spurious

    do_load(16'h1000, 1'b1, 1'b0, 1'b0, 0, 0);  // recovers after reset
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      chk("drain", 32'(exp_q.size()), 32'd0);
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/reg_load_seq.md
REG_LOAD_SEQ -- requirements
Module: reg_load_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have the port ld_start, input, 1 bit: load request, sampled only in IDLE.
REQ-004 The block SHALL have the port ld_addr, input, 16 bits: byte address of the word to load.
REQ-005 The block SHALL have the port ld_dest, input, 1 bit: destination register select (0 = A, 1 = B).
REQ-006 The block SHALL have the port ld_byte, input, 1 bit: byte load (1) or word load (0).
REQ-007 The block SHALL have the port ld_sext, input, 1 bit: for byte loads, sign-extend (1) or zero-extend (0).
REQ-008 The block SHALL have the port busy, output, 1 bit: high from the cycle after acceptance through the WRITE cycle.
REQ-009 The block SHALL have the port mem_addr, output, 16 bits: byte address presented to memory.
REQ-010 The block SHALL have the port mem_req, output, 1 bit: memory read request, held until mem_ack.
REQ-011 The block SHALL have the port mem_ack, input, 1 bit: memory read data valid.
REQ-012 The block SHALL have the port mem_rdata, input, 8 bits: memory read byte.
REQ-013 The block SHALL have the port sec_out, output, 16 bits: assembled value, wired to the sec_in port of both general registers.
REQ-014 The block SHALL have the port sec_we_a, output, 1 bit: one-cycle write strobe to register A.
REQ-015 The block SHALL have the port sec_we_b, output, 1 bit: one-cycle write strobe to register B.

Function
REQ-016 The block SHALL implement four states: IDLE, RD_LO, RD_HI, WRITE.
REQ-017 In IDLE with ld_start=1, the block SHALL latch ld_addr, ld_dest, ld_byte and ld_sext, and SHALL enter RD_LO on the next edge.
REQ-018 In RD_LO, the block SHALL drive mem_req=1 and mem_addr equal to the latched address.
REQ-019 On mem_ack in RD_LO, the block SHALL capture mem_rdata into the low byte, then enter RD_HI for a word load or WRITE for a byte load.
REQ-020 In RD_HI, the block SHALL drive mem_req=1 and mem_addr equal to the latched address + 1, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-021 On mem_ack in RD_HI, the block SHALL capture mem_rdata into the high byte (little-endian) and enter WRITE.
REQ-022 While mem_ack=0, the block SHALL hold its state, mem_req and mem_addr unchanged, with no timeout.
REQ-023 mem_ack SHALL be ignored in IDLE and WRITE.
REQ-024 For a byte load, the high byte SHALL be 0x00 when ld_sext=0 and SHALL be replicated from bit 7 of the low byte when ld_sext=1.
REQ-025 In WRITE, the block SHALL assert exactly one of sec_we_a or sec_we_b (per the latched dest) for exactly one cycle, and SHALL return to IDLE on the next edge.
REQ-026 sec_out SHALL show the assembled value during WRITE; its value outside WRITE is don't-care.
REQ-027 ld_start while busy=1 SHALL be ignored; no request is queued.
REQ-028 A new ld_start SHALL be accepted in the IDLE cycle immediately after WRITE, so back-to-back loads are possible.
REQ-029 Minimum latency from ld_start to the write strobe SHALL be 3 cycles for a word load and 2 cycles for a byte load, with zero-wait mem_ack.
REQ-030 The block SHALL assert mem_req only in RD_LO and RD_HI.

Reset
REQ-031 On rst=1, the block SHALL asynchronously enter IDLE, with busy=0, mem_req=0, sec_we_a=0, sec_we_b=0, mem_addr=0x0000 and sec_out=0x0000.
REQ-032 Asserting rst mid-load SHALL abandon the load; no write strobe is issued after rst deasserts.

Structure
REQ-033 State encoding (2 bits) and the DEST_A=0 / DEST_B=1 constants SHALL reside in the shared CPU package.
REQ-034 The design SHALL be a single module with no sub-module; the address increment and byte extension are inline logic.

Verification
REQ-035 Word load with zero-wait memory: addr 0x1000 holding 0x34 at 0x1000 and 0x12 at 0x1001, dest A -> sec_out=0x1234 and sec_we_a pulses 3 cycles after ld_start.
REQ-036 Byte load with sign extension: memory byte 0x80, dest B -> sec_out=0xFF80 with sec_we_b; the same with ld_sext=0 -> 0x0080.
REQ-037 Address wrap: word load from 0xFFFF -> second mem_addr is 0x0000 and the result assembles bytes 0xFFFF and 0x0000.
REQ-038 Wait states: mem_ack delayed 4 cycles per byte -> mem_req and mem_addr are held stable, exactly one write strobe, correct value.
REQ-039 ld_start pulsed while busy -> ignored; a back-to-back ld_start in the IDLE cycle after WRITE -> accepted.
REQ-040 rst asserted in RD_HI -> immediate IDLE with all outputs at reset values, and no sec_we_a or sec_we_b pulse afterwards.
